sum_packet_arbiter: RTL and testbench
=====================================

# sum_packet_arbiter

Round-robin, packet-granular arbiter that shares one `Sum` accumulator between `NOF_REQ` packet sources. It grants one requester at a time, streams that requester's beats into the Sum datapath, and fills gaps with zeros. It then captures the Sum result and returns it tagged with the requester ID. It sits directly in front of `Sum` and drives its `data_first`/`data_last`/`data_in`; it observes `busy`/`done`/`data_out`.

## Interface
- `NOF_REQ`, default 4: number of requesters, ≥2. `ID_W = max(1, clog2(NOF_REQ))`.
- `NOF_BITS`, default 32: data width. It matches the Sum instance.
- `DONE_TIMEOUT`, default 8: maximum cycles in WAIT_DONE before the error exit, ≥4.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NOF_REQ  beat valid per requester.
- `req_first`  in  NOF_REQ  beat is first of packet.
- `req_last`  in  NOF_REQ  beat is last of packet.
- `req_data`  in  NOF_REQ*NOF_BITS  requester i occupies `[i*NOF_BITS +: NOF_BITS]`.
- `req_ready`  out  NOF_REQ  beat accepted when `valid&ready`.
- `sum_first`, `sum_last`  out  1 each  registered, to Sum `data_first`/`data_last`.
- `sum_data`  out  NOF_BITS  registered, to Sum `data_in`.
- `sum_busy`, `sum_done`  in  1 each  from Sum.
- `sum_result`  in  NOF_BITS+1  from Sum `data_out`.
- `res_valid`  out  1  one-cycle pulse, result ready.
- `res_id`  out  ID_W  requester that owns the result or the error.
- `res_sum`  out  NOF_BITS+1  captured sum.
- `err`  out  1  one-cycle pulse on a done timeout.
- `ctrl_busy`  out  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, STREAM and WAIT_DONE. Reset enters IDLE.
- IDLE: the candidates are the requesters with `req_valid[i] & req_first[i]`. Arbitration is blocked while `sum_busy=1`.
  - The winner is the first candidate searching upward from `last_grant+1`, wrapping at NOF_REQ.
  - On a win: register `grant_id` and `last_grant`, then go to STREAM.
  - `req_ready` is 0 in IDLE.
- STREAM: `req_ready[grant_id]=1`; all other ready bits are 0.
  - Each accepted beat registers `sum_data=req_data[grant]`.
  - `sum_first=1` only on the first accepted beat of the grant. `req_first` on later beats is ignored.
  - `sum_last=req_last[grant]` on each accepted beat.
  - A cycle with no accepted beat registers `sum_data=0`, `sum_first=0`, `sum_last=0`. Sum adds 0 every BUSY cycle, so gaps are harmless.
  - Accepting a beat with `req_last=1` moves the state to WAIT_DONE.
  - A packet with first and last on the same beat is legal.
- WAIT_DONE: `req_ready=0`; `sum_*` outputs are driven to 0. A cycle counter starts at 0 on entry.
  - When `sum_done=1` is sampled: register `res_sum=sum_result`, `res_id=grant_id`, and pulse `res_valid` in the next cycle. Go to IDLE.
  - If the counter reaches DONE_TIMEOUT-1 without `sum_done`: pulse `err` with `res_id=grant_id`. `res_valid` stays 0 and `res_sum` is unchanged. Go to IDLE.
- `res_sum`/`res_id` hold their values between pulses.
- Sum width is NOF_BITS+1, and the final carry is preserved. Overflow beyond NOF_BITS+1 bits is Sum's behaviour and is not checked here.
- Requesters hold valid data stable until it is accepted. A valid beat without first, offered in IDLE, is never granted and stays stalled.

## Timing
- Reset values: all outputs 0, `grant_id=0`, `last_grant=NOF_REQ-1`, so requester 0 wins the first arbitration.
- Reset mid-packet aborts the packet with no `res_valid` or `err`. Sum shares `rst_n`.
- Single beat, offered at cycle 0 in IDLE:
  - cycle 1: grant and accept.
  - cycle 2: Sum sees the beat.
  - cycle 3: Sum is in DONE.
  - cycle 4: `sum_done` is high.
  - cycle 5: `res_valid` is high.
- An N-beat packet without gaps produces `res_valid` at cycle N+4. Each gap cycle adds 1.
- The controller is back in IDLE during the `res_valid` cycle, so a waiting requester is granted then and streams from the next cycle. Packet-to-packet overhead is 4 cycles.
- Simultaneous candidates are resolved by the rotating pointer. Each requester is starved for at most NOF_REQ-1 packets.

## Test plan
- Reset, then requester 0 sends 3,5,7 with first on 3 and last on 7, no gaps → `res_valid` at cycle 7, `res_id=0`, `res_sum=15`.
- All 4 requesters offer a single-beat packet (values 1,2,3,4) at cycle 0 → results come out in order ID 0,1,2,3 with sums 1,2,3,4, spaced 5 cycles apart.
- Requester 2 sends 0xFFFFFFFF and 0x00000001 with 2 idle cycles between beats → `res_sum=0x100000000`, `res_valid` 2 cycles later than the gap-free case.
- Hold `sum_done=0` using a stub in place of Sum → `err` pulses in the 8th WAIT_DONE cycle, no `res_valid`, return to IDLE.
- Assert `rst_n=0` during STREAM of a 5-beat packet → all outputs 0 immediately, no result; the next packet sums correctly.
- `sum_busy` held at 1 with requester 1 pending → no grant until `sum_busy` falls.

Source files
------------

// File: rtl/sum_packet_arbiter.sv
// sum_packet_arbiter: round-robin packet arbiter that feeds one shared Sum accumulator and returns tagged results
module sum_packet_arbiter #(
  parameter int NOF_REQ = 4,
  parameter int NOF_BITS = 32,
  parameter int DONE_TIMEOUT = 8,
  localparam int ID_W = (NOF_REQ > 2) ? $clog2(NOF_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NOF_REQ-1:0]          req_valid,
  input  logic [NOF_REQ-1:0]          req_first,
  input  logic [NOF_REQ-1:0]          req_last,
  input  logic [NOF_REQ*NOF_BITS-1:0] req_data,
  output logic [NOF_REQ-1:0]          req_ready,
  output logic                        sum_first,
  output logic                        sum_last,
  output logic [NOF_BITS-1:0]         sum_data,
  input  logic                        sum_busy,
  input  logic                        sum_done,
  input  logic [NOF_BITS:0]           sum_result,
  output logic                        res_valid,
  output logic [ID_W-1:0]             res_id,
  output logic [NOF_BITS:0]           res_sum,
  output logic                        err,
  output logic                        ctrl_busy
);
  localparam int CNT_W = $clog2(DONE_TIMEOUT);
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] grant_id, last_grant, win_id;
  logic [NOF_REQ-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic win, accept, first_beat, timeout, got_done, err_set, do_grant;
  always_comb begin
    cand = req_valid & req_first;
    win = 1'b0;
    win_id = '0;
    for (int k = 1; k <= NOF_REQ; k++)
      if (!win && cand[(int'(last_grant) + k) % NOF_REQ]) begin
        win = 1'b1;
        win_id = ID_W'((int'(last_grant) + k) % NOF_REQ);
      end
  end
  assign do_grant  = state == IDLE && !sum_busy && win;
  assign accept    = state == STREAM && req_valid[grant_id];
  assign timeout   = cnt == CNT_W'(DONE_TIMEOUT - 1);
  assign got_done  = state == WAIT_DONE && sum_done && !timeout;
  // err is registered one cycle early so it lands on the last WAIT_DONE cycle
  assign err_set   = state == WAIT_DONE && !sum_done && cnt == CNT_W'(DONE_TIMEOUT - 2);
  assign req_ready = state == STREAM ? NOF_REQ'(1) << grant_id : '0;
  assign ctrl_busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = do_grant ? STREAM : IDLE;
      STREAM:    state_nx = accept && req_last[grant_id] ? WAIT_DONE : STREAM;
      WAIT_DONE: state_nx = timeout || sum_done ? IDLE : WAIT_DONE;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_id   <= '0;
      last_grant <= ID_W'(NOF_REQ - 1);
      first_beat <= 1'b0;
      sum_first  <= 1'b0;
      sum_last   <= 1'b0;
      sum_data   <= '0;
      cnt        <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_sum    <= '0;
      err        <= 1'b0;
    end else begin
      if (do_grant) begin
        grant_id   <= win_id;
        last_grant <= win_id;
      end
      first_beat <= do_grant | (first_beat & ~accept);
      sum_data   <= accept ? req_data[grant_id*NOF_BITS +: NOF_BITS] : '0;
      sum_first  <= accept & first_beat;
      sum_last   <= accept & req_last[grant_id];
      cnt        <= state == WAIT_DONE ? cnt + 1'b1 : '0;
      res_valid  <= got_done;
      err        <= err_set;
      if (got_done) res_sum <= sum_result;
      if (got_done || err_set) res_id <= grant_id;
    end
endmodule

// File: tb/tb_sum_packet_arbiter.sv
// tb_sum_packet_arbiter: directed scoreboard bench with a behavioural Sum model behind the arbiter
module tb_sum_packet_arbiter;
  typedef struct {logic [31:0] d; bit f; bit l; int gap;} beat_t;
  typedef struct {bit is_err; int id; logic [32:0] sum; int at;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req_valid = '0, req_first = '0, req_last = '0, req_ready, took = '0;
  logic [127:0] req_data = '0;
  logic sum_first, sum_last, sum_busy, sum_done, res_valid, err, ctrl_busy;
  logic [31:0] sum_data;
  logic [32:0] sum_result, res_sum;
  logic [1:0] res_id;
  logic busy_force = 1'b0, hold_done = 1'b0;
  logic [1:0] ms;
  logic [32:0] acc, m_res;
  logic m_done;
  int checks = 0, errors = 0, cyc = 0, c0;
  beat_t bq[4][$];
  exp_t sb[$];
  exp_t e;

  sum_packet_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_first(req_first), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .sum_first(sum_first), .sum_last(sum_last),
    .sum_data(sum_data), .sum_busy(sum_busy), .sum_done(sum_done), .sum_result(sum_result),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum), .err(err), .ctrl_busy(ctrl_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Sum model: IDLE -> BUSY on first, DONE after last, done/result registered out of DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ms <= 2'd0; acc <= '0; m_res <= '0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (ms)
        2'd0: if (sum_first) begin acc <= {1'b0, sum_data}; ms <= sum_last ? 2'd2 : 2'd1; end
        2'd1: begin acc <= acc + {1'b0, sum_data}; if (sum_last) ms <= 2'd2; end
        default: begin m_done <= 1'b1; m_res <= acc; ms <= 2'd0; end
      endcase
    end
  assign sum_busy = (ms != 2'd0) | busy_force;
  assign sum_done = m_done & ~hold_done;
  assign sum_result = m_res;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic beat(input int id, input logic [31:0] d, input bit f, input bit l, input int g);
    beat_t b;
    b.d = d; b.f = f; b.l = l; b.gap = g;
    bq[id].push_back(b);
  endtask

  task automatic expect_out(input bit is_err, input int id, input logic [32:0] s, input int at);
    exp_t x;
    x.is_err = is_err; x.id = id; x.sum = s; x.at = at;
    sb.push_back(x);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (sb.size() > 0 && n < lim) begin @(negedge clk); n++; end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 64'({req_ready, sum_first, sum_last, res_valid, res_id, err, ctrl_busy}), 64'd0);
    chk({tag, "_sum_data"}, 64'(sum_data), 64'd0);
    chk({tag, "_res_sum"}, 64'(res_sum), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) bq[i].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) took = req_valid & req_ready;

  // requester driver: presents queue heads, pops accepted beats, honours per-beat idle gaps
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (took[i] && bq[i].size() > 0) void'(bq[i].pop_front());
      if (bq[i].size() > 0) begin
        if (bq[i][0].gap > 0) begin
          bq[i][0].gap = bq[i][0].gap - 1;
          req_valid[i] = 1'b0;
        end else req_valid[i] = 1'b1;
        req_first[i] = bq[i][0].f;
        req_last[i] = bq[i][0].l;
        req_data[i*32 +: 32] = bq[i][0].d;
      end else begin
        req_valid[i] = 1'b0; req_first[i] = 1'b0; req_last[i] = 1'b0; req_data[i*32 +: 32] = '0;
      end
    end
  end

  always @(negedge clk)
    if (rst_n && (res_valid || err)) begin
      chk("out_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_kind", 64'({res_valid, err}), e.is_err ? 64'd1 : 64'd2);
        chk("out_id", 64'(res_id), 64'(e.id));
        chk("out_sum", 64'(res_sum), 64'(e.sum));
        chk("out_cycle", 64'(cyc), 64'(e.at));
      end
    end

  initial begin
    #1 check_zero("reset_initial");
    do_reset();
    // three-beat packet from requester 0
    @(negedge clk); c0 = cyc + 1;
    beat(0, 3, 1, 0, 0); beat(0, 5, 0, 0, 0); beat(0, 7, 0, 1, 0);
    expect_out(0, 0, 33'd15, c0 + 7);
    drain(40);
    // four simultaneous single-beat packets after a fresh reset
    do_reset();
    @(negedge clk); c0 = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      beat(i, i + 1, 1, 1, 0);
      expect_out(0, i, 33'(i + 1), c0 + 5 * (i + 1));
    end
    drain(60);
    // carry out of 32 bits with two idle cycles between beats
    @(negedge clk); c0 = cyc + 1;
    beat(2, 32'hFFFF_FFFF, 1, 0, 0); beat(2, 32'h1, 0, 1, 2);
    expect_out(0, 2, 33'h1_0000_0000, c0 + 8);
    drain(40);
    // done never arrives: error on the 8th WAIT_DONE cycle, result held
    hold_done = 1'b1;
    @(negedge clk); c0 = cyc + 1;
    beat(3, 32'd9, 1, 1, 0);
    expect_out(1, 3, 33'h1_0000_0000, c0 + 9);
    drain(40);
    chk("timeout_idle", 64'({ctrl_busy, res_valid, err}), 64'd0);
    hold_done = 1'b0;
    // reset in the middle of a five-beat packet
    @(negedge clk); c0 = cyc + 1;
    for (int i = 0; i < 5; i++) beat(0, 32'(10 + i), i == 0, i == 4, 0);
    repeat (3) @(negedge clk);
    chk("mid_stream_busy", 64'({ctrl_busy, req_ready}), 64'h11);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) bq[i].delete();
    #1 check_zero("reset_mid_packet");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); c0 = cyc + 1;
    beat(0, 32'd100, 1, 0, 0); beat(0, 32'd200, 0, 1, 0);
    expect_out(0, 0, 33'd300, c0 + 6);
    drain(40);
    // Sum busy blocks arbitration
    @(negedge clk);
    busy_force = 1'b1;
    beat(1, 32'd42, 1, 1, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("busy_no_grant", 64'({ctrl_busy, req_ready}), 64'd0);
    end
    busy_force = 1'b0;
    expect_out(0, 1, 33'd42, cyc + 5);
    drain(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
